fml_ram_responder: RTL
======================

# fml_ram_responder

Synthesizable FML slave that terminates the memory side of the FML bus, where the 16-bit DDR interface and the DDR controller sit. It accepts 4-beat FML bursts from an initiator such as the Wishbone-to-FML bridge. It services them from an internal byte-enabled 32-bit RAM with programmable access latency and back-pressure. Used as a deterministic memory endpoint for bridge and arbiter bring-up, without the DDR model.

## Interface
- `fml_depth`, default 26: FML byte-address width.
- `mem_depth`, default 10: log2 of RAM size in 32-bit words.
- `ack_latency`, default 3: cycles from request acceptance to `fml_ack`; legal range 1–15.
- `sys_clk`  in  1  system clock; all logic on rising edge.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `fml_adr`  in  fml_depth  burst byte address.
- `fml_stb`  in  1  request strobe, held until ack.
- `fml_we`  in  1  1 = write burst, 0 = read burst.
- `fml_sel`  in  4  per-beat byte enables for write beats; bit i enables byte lane i (bits 8i+7:8i).
- `fml_di`  in  32  write data beats.
- `fml_do`  out  32  read data beats.
- `fml_ack`  out  1  one-cycle request acknowledge.
- `stall`  in  1  back-pressure; holds off `fml_ack`.
- `rd_count`  out  16  completed read bursts (see Configuration).
- `wr_count`  out  16  completed write bursts (see Configuration).

## Operation
- States: IDLE, WAIT, ACK, BURST.
- IDLE:
  - When `fml_stb`=1, latch `fml_adr` and `fml_we`.
  - Load the latency counter with `ack_latency`-1.
  - Go to WAIT, or go directly to ACK if the loaded value is 0.
- WAIT:
  - Decrement the counter each cycle.
  - At 0, go to ACK.
- ACK:
  - `fml_ack`=1 only in a cycle where `stall`=0. While `stall`=1, remain in ACK with `fml_ack`=0.
  - After the ack cycle, go to BURST with beat index 0.
- BURST: 4 beats, beat index 0..3, then return to IDLE.
- Addressing:
  - Line base = `fml_adr[mem_depth+1:4]`.
  - Beat k accesses word {base, (`fml_adr[3:2]`+k) mod 4]}. The first beat is the critical word; the order wraps within the 16-byte line.
  - `fml_adr[1:0]` is ignored.
  - Address bits above `mem_depth+1` are ignored, so addresses alias.
- Write beat:
  - Each byte lane with `fml_sel` bit set is written from `fml_di`.
  - Lanes with a clear bit keep their old contents.
  - `fml_sel`=0 on a beat is a legal no-op.
- Read beat: `fml_do` = addressed word. `fml_do`=0 in every cycle that is not a read beat.
- `fml_stb`, `fml_adr` and `fml_we` are ignored outside IDLE.
- `stall` is ignored outside ACK. Beats are never stalled.
- Reset:
  - Asynchronous, effective immediately, including mid-burst.
  - Outputs go to 0 and state to IDLE. The remaining beats of any burst in progress are abandoned.
  - Write beats already committed stay in RAM. RAM contents are not cleared by reset.
- RAM initial contents are undefined. The bench preloads the RAM or writes before reading.

## Timing
- Request sampled in IDLE at cycle T. With `stall`=0, `fml_ack`=1 at T+`ack_latency`, for exactly one cycle.
- Beats occupy cycles A+1 .. A+4, where A is the ack cycle.
- Write data:
  - `fml_di` and `fml_sel` are sampled at A+1 .. A+4.
  - A read at a later burst returns the updated data.
- Read data: `fml_do` is registered and valid at A+1 .. A+4.
- Returns to IDLE at A+5. Earliest next acceptance is A+5, so back-to-back bursts are spaced by at least `ack_latency`+5 cycles.
- Reset values: `fml_ack`=0, `fml_do`=0, `rd_count`=0, `wr_count`=0.

## Configuration
- `FML_RESPONDER_STATS_EN` defined:
  - `rd_count` increments at the last beat of each completed read burst; `wr_count` does the same for write bursts.
  - Both counters are 16 bits and wrap from 0xFFFF to 0.
  - A burst abandoned by reset is not counted.
- Macro undefined: no counters are synthesized, and `rd_count` and `wr_count` are tied to 0.

## Test plan
- Basic write then read:
  - Stimulus: `ack_latency`=3. Write burst at 0x100 with `fml_sel`=0xF and beats 0xABADFACE, 0x11111111, 0x22222222, 0x33333333. Then read burst at 0x100.
  - Response: `fml_ack` 3 cycles after `fml_stb`. Read beats return the same 4 words in order at A+1..A+4.
- Partial write with byte enables:
  - Stimulus: word 0x200 holds 0xFFFFFFFF. Write burst at 0x200 with beat 0 = 0x12345678 and `fml_sel`=0x5; beats 1–3 have `fml_sel`=0.
  - Response: read of 0x200 returns 0xFF34FF78 on beat 0.
- Wrapping burst order:
  - Stimulus: words 0x300..0x30C hold 0,1,2,3. Read burst at 0x308.
  - Response: beats return 2,3,0,1.
- Back-pressure:
  - Stimulus: `stall`=1 for 10 cycles starting before the latency expires.
  - Response: `fml_ack` is first asserted on the first cycle with `stall`=0. `fml_do` stays 0 until A+1.
- Reset mid-burst:
  - Stimulus: assert `sys_rst` during write beat 2 of a burst at 0x400 writing 0xA0, 0xA1, 0xA2, 0xA3, then release and read back 0x400.
  - Response: `fml_ack` and `fml_do` are 0 immediately on reset. Read returns 0xA0, 0xA1 and the old contents for beats 2–3.
- Statistics counters:
  - Stimulus: with `FML_RESPONDER_STATS_EN` defined, run 3 writes and 2 reads.
  - Response: `wr_count`=3, `rd_count`=2. With the macro undefined, both read 0.

Source files
------------

// File: rtl/fml_ram_responder_if.sv
// FML bus bundle between an initiator (master) and a memory endpoint (slave).
// Burst address, strobe, direction, byte enables, data beats and acknowledge.
interface fml_ram_responder_if #(
    parameter int fml_depth = 26
);
    logic [fml_depth-1:0] fml_adr;
    logic                 fml_stb;
    logic                 fml_we;
    logic [3:0]           fml_sel;
    logic [31:0]          fml_di;
    logic [31:0]          fml_do;
    logic                 fml_ack;

    modport master (
        output fml_adr,
        output fml_stb,
        output fml_we,
        output fml_sel,
        output fml_di,
        input  fml_do,
        input  fml_ack
    );

    modport slave (
        input  fml_adr,
        input  fml_stb,
        input  fml_we,
        input  fml_sel,
        input  fml_di,
        output fml_do,
        output fml_ack
    );
endinterface

// File: rtl/fml_ram_responder.sv
// FML slave answering 4-beat critical-word-first bursts from a byte-enabled RAM.
// Optional burst counters are built when FML_RESPONDER_STATS_EN is defined.
module fml_ram_responder #(
    parameter int fml_depth   = 26,
    parameter int mem_depth   = 10,
    parameter int ack_latency = 3
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    fml_ram_responder_if.slave    fml,
    input  logic                  stall,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    localparam int BW = mem_depth - 2;
    localparam logic [3:0] LAT_LOAD = 4'(ack_latency - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_BURST
    } state_t;

    state_t          state, state_n;
    logic [3:0]      cnt, cnt_n;
    logic [1:0]      beat, beat_n;
    logic [BW-1:0]   base, base_n;
    logic [1:0]      off, off_n;
    logic            we_q, we_n;
    logic            ack;

    logic [31:0]          mem [2**mem_depth];
    logic [31:0]          do_q;
    logic                 rd_en;
    logic                 wr_en;
    logic [1:0]           rd_step;
    logic [mem_depth-1:0] rd_idx;
    logic [mem_depth-1:0] wr_idx;

    // Low byte-offset bits and aliased high bits play no part in addressing.
    logic unused_adr;
    assign unused_adr = ^{fml.fml_adr[fml_depth-1:mem_depth+2],
                          fml.fml_adr[1:0]};

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            beat  <= '0;
            base  <= '0;
            off   <= '0;
            we_q  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            beat  <= beat_n;
            base  <= base_n;
            off   <= off_n;
            we_q  <= we_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        beat_n  = beat;
        base_n  = base;
        off_n   = off;
        we_n    = we_q;
        ack     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (fml.fml_stb) begin
                    base_n  = fml.fml_adr[mem_depth+1:4];
                    off_n   = fml.fml_adr[3:2];
                    we_n    = fml.fml_we;
                    cnt_n   = LAT_LOAD;
                    state_n = (LAT_LOAD == 4'd0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                // The ack cycle itself is the last latency cycle.
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n = S_ACK;
                end
            end
            S_ACK: begin
                if (!stall) begin
                    ack     = 1'b1;
                    beat_n  = 2'd0;
                    state_n = S_BURST;
                end
            end
            S_BURST: begin
                beat_n = beat + 2'd1;
                if (beat == 2'd3) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign fml.fml_ack = ack;

    // Read data is fetched one cycle ahead so each beat is registered.
    assign rd_step = (state == S_BURST) ? beat + 2'd1 : 2'd0;
    assign rd_idx  = {base, off + rd_step};
    assign rd_en   = !we_q &&
                     ((state == S_ACK && !stall) ||
                      (state == S_BURST && beat != 2'd3));

    assign wr_idx = {base, off + beat};
    assign wr_en  = we_q && (state == S_BURST);

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (fml.fml_sel[i]) begin
                    mem[wr_idx][8*i +: 8] <= fml.fml_di[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            do_q <= '0;
        end else if (rd_en) begin
            do_q <= mem[rd_idx];
        end else begin
            do_q <= '0;
        end
    end

    assign fml.fml_do = do_q;

`ifdef FML_RESPONDER_STATS_EN
    logic        last_beat;
    logic [15:0] rd_q;
    logic [15:0] wr_q;

    assign last_beat = (state == S_BURST) && (beat == 2'd3);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rd_q <= '0;
            wr_q <= '0;
        end else if (last_beat) begin
            if (we_q) begin
                wr_q <= wr_q + 16'd1;
            end else begin
                rd_q <= rd_q + 16'd1;
            end
        end
    end

    assign rd_count = rd_q;
    assign wr_count = wr_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule
